// File: rtl/mtm_alu_sin_rx.sv
`default_nettype none
// ============================================================================
// Module   : mtm_alu_sin_rx
// Brief    : Serial packet receiver for the ALU. It decodes 11-bit frames on
//            sin and assembles 8 data frames plus 1 command frame into A, B
//            and OP. Each packet produces a one-cycle out_valid strobe and a
//            3-bit error code.
//            Optional CRC4 checking is enabled with the macro
//            MTM_ALU_SIN_RX_CRC_CHECK_EN.
// Revision : 1.0 - initial release
// ============================================================================
module mtm_alu_sin_rx (
    input  logic        clk,
    input  logic        rst,
    input  logic        sin,
    output logic [31:0] A,
    output logic [31:0] B,
    output logic [2:0]  OP,
    output logic [2:0]  ERR,
    output logic        out_valid
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_TYPE = 2'd1,
        S_DATA = 2'd2,
        S_STOP = 2'd3
    } state_t;

    localparam logic [3:0] c_FRAMES_FULL = 4'd8;
    localparam logic [3:0] c_FRAMES_SAT  = 4'd9;
    localparam logic [2:0] c_ERR_DATA    = 3'b100;
    localparam logic [2:0] c_ERR_CRC     = 3'b010;
    localparam logic [2:0] c_ERR_OP      = 3'b001;
    localparam logic [2:0] c_ERR_NONE    = 3'b000;

    state_t      r_state;
    logic [2:0]  r_bit_cnt;
    logic        r_is_cmd;
    logic [7:0]  r_byte;
    logic [63:0] r_shift;
    logic [3:0]  r_frame_cnt;
    logic        r_need_high;

    logic        w_pkt_end;
    logic        w_crc_err;
    logic        w_op_ok;
    logic [2:0]  w_err;

    // A packet ends on any cmd stop bit or on a framing error in any frame.
    assign w_pkt_end = (r_state == S_STOP) && (r_is_cmd || !sin);

    // Only AND, OR, ADD and SUB are legal. Each of these has OP[1] = 0.
    assign w_op_ok = ~r_byte[5];

`ifdef MTM_ALU_SIN_RX_CRC_CHECK_EN
    logic [3:0] r_crc;
    logic       w_crc_en;
    logic       w_crc_bit;
    logic       w_crc_fb;
    logic [3:0] w_crc_next;

    // Cmd payload bit 7 is replaced by a constant 1.
    // Only the OP bits that follow it feed the LFSR.
    always_comb begin
        w_crc_en   = (r_state == S_DATA) && (!r_is_cmd || (r_bit_cnt <= 3'd3));
        w_crc_bit  = (r_is_cmd && (r_bit_cnt == 3'd0)) ? 1'b1 : sin;
        w_crc_fb   = r_crc[3] ^ w_crc_bit;
        w_crc_next = {r_crc[2], r_crc[1], r_crc[0] ^ w_crc_fb, w_crc_fb};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_crc <= 4'b0000;
        end else if (w_pkt_end) begin
            r_crc <= 4'b0000;
        end else if (w_crc_en) begin
            r_crc <= w_crc_next;
        end
    end

    assign w_crc_err = (r_crc != r_byte[3:0]);
`else
    assign w_crc_err = 1'b0;
`endif

    always_comb begin
        w_err = c_ERR_NONE;
        if (r_frame_cnt != c_FRAMES_FULL) begin
            w_err = c_ERR_DATA;
        end else if (w_crc_err) begin
            w_err = c_ERR_CRC;
        end else if (!w_op_ok) begin
            w_err = c_ERR_OP;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_bit_cnt   <= 3'd0;
            r_is_cmd    <= 1'b0;
            r_byte      <= 8'h00;
            r_shift     <= 64'd0;
            r_frame_cnt <= 4'd0;
            r_need_high <= 1'b0;
            A           <= 32'd0;
            B           <= 32'd0;
            OP          <= 3'b000;
            ERR         <= c_ERR_NONE;
            out_valid   <= 1'b0;
        end else begin
            out_valid <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    // After a framing error the line must return high
                    // before a new start bit is accepted.
                    if (r_need_high) begin
                        if (sin) begin
                            r_need_high <= 1'b0;
                        end
                    end else if (!sin) begin
                        r_state <= S_TYPE;
                    end
                end
                S_TYPE: begin
                    r_is_cmd  <= sin;
                    r_bit_cnt <= 3'd0;
                    r_state   <= S_DATA;
                end
                S_DATA: begin
                    r_byte    <= {r_byte[6:0], sin};
                    r_bit_cnt <= r_bit_cnt + 3'd1;
                    if (r_bit_cnt == 3'd7) begin
                        r_state <= S_STOP;
                    end
                end
                S_STOP: begin
                    r_state <= S_IDLE;
                    if (!sin) begin
                        out_valid   <= 1'b1;
                        ERR         <= c_ERR_DATA;
                        r_frame_cnt <= 4'd0;
                        r_need_high <= 1'b1;
                    end else if (r_is_cmd) begin
                        out_valid   <= 1'b1;
                        B           <= r_shift[63:32];
                        A           <= r_shift[31:0];
                        OP          <= r_byte[6:4];
                        ERR         <= w_err;
                        r_frame_cnt <= 4'd0;
                    end else begin
                        r_shift <= {r_shift[55:0], r_byte};
                        if (r_frame_cnt != c_FRAMES_SAT) begin
                            r_frame_cnt <= r_frame_cnt + 4'd1;
                        end
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire
